cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control unit for the RV32I core. It owns the PC and instruction register and steps each instruction through fetch, decode, execute, memory and writeback. It multiplexes the single shared memory port between instruction fetch and load/store traffic, and aligns load and store data. It sits between the memory port, the combinational decoder/executor and the register file.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk_in  input  1  core clock
- rst_n_in  input  1  asynchronous, active-low reset
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- mem_req_we  output  1  1 = store
- mem_req_wdata  output  32  lane-shifted store data
- mem_req_be  output  4  store byte enables; 4'b0000 on reads
- mem_resp_valid  input  1  read data valid (one-cycle pulse)
- mem_resp_data  input  32  read word
- inst  output  32  instruction register, drives decoder
- d_itype  input  IType  decoded instruction class
- d_memfunc  input  MemFunc  decoded memory function
- d_dst  input  5  destination register
- x_data  input  32  execute result (ALU result or store data)
- x_addr  input  32  execute effective address
- x_next_pc  input  32  execute next PC
- pc  output  32  current PC
- rf_we  output  1  register-file write strobe
- rf_waddr  output  5  write register
- rf_wdata  output  32  write data
- retire  output  1  one-cycle pulse per completed instruction
- halted  output  1  sticky; set on illegal or misaligned instruction
- cycle_count  output  32  performance counter (see Configuration)
- instret_count  output  32  performance counter (see Configuration)

## Operation
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT.
- FETCH_REQ
  - Drives mem_req_valid=1, addr=pc, we=0.
  - Moves to FETCH_WAIT when mem_req_valid && mem_req_ready.
- FETCH_WAIT: on mem_resp_valid, inst ← mem_resp_data, then DECODE.
- DECODE: one settle cycle for the decoder; registers d_itype, d_memfunc and d_dst. Moves to EXECUTE.
- EXECUTE: registers x_data, x_addr and x_next_pc, then branches on itype:
  - Unsupported → HALT.
  - LOAD/STORE misaligned → HALT. Misaligned means Lw/Sw with addr[1:0]≠0, or Lh/Lhu/Sh with addr[0]=1.
  - Other LOAD/STORE → MEM_REQ.
  - Anything else → WRITEBACK.
- MEM_REQ
  - Drives the request at x_addr. Stores set we=1.
  - Store byte enables and data:
    - Sb: be = 4'b0001<<addr[1:0], wdata = {4{x_data[7:0]}}.
    - Sh: be = 4'b0011<<addr[1:0], wdata = {2{x_data[15:0]}}.
    - Sw: be = 4'b1111.
  - On accept: stores → WRITEBACK, loads → MEM_WAIT.
- MEM_WAIT: on mem_resp_valid, selects the byte/half lane by addr[1:0], extends it (sign for Lb/Lh, zero for Lbu/Lhu), latches it as load data, then WRITEBACK.
- WRITEBACK
  - rf_we=1 when itype ∈ {OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD, PMUL} and d_dst≠0.
  - rf_wdata is the load data for LOAD, otherwise x_data.
  - pc ← x_next_pc; retire=1; then FETCH_REQ.
- HALT: terminal; halted=1; no requests; leaves only via reset.
- The memory port has at most one outstanding request. mem_resp_valid in any state other than FETCH_WAIT/MEM_WAIT is ignored.

## Timing
- Reset values:
  - state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013.
  - mem_req_valid=0, we=0, be=0, addr/wdata=0.
  - rf_we=0, retire=0, halted=0, counters=0.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational path.
- Request handshake: mem_req_valid and its address/data/be hold stable until the cycle in which mem_req_ready=1. Dropping valid before acceptance is a defect.
- The earliest response is the cycle after acceptance.
- Zero-wait memory (ready=1, response one cycle after accept):
  - ALU/branch/jump instruction: 5 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
- An asynchronous reset mid-transaction abandons the transaction. A response arriving after reset release, while in FETCH_REQ, is dropped.
- A retire pulse and the pc update occur in the same clock edge that leaves WRITEBACK.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_count increments every cycle after reset, including HALT.
  - instret_count increments on each retire.
  - Both wrap modulo 2^32.
- SEQ_PERF_CNT_EN undefined: both outputs are tied to 32'h0 and the counter registers are not built.

## Structure
- Package proc_types_pkg holds:
  - IType, AluFunc, BrFunc, MemFunc, DecodedInst, ExecInst.
  - The opcode/funct3 constants.
  - The sequencer state enum seq_state_t.
- Sub-module mem_align (combinational) holds:
  - Store inputs memFunc, addr[1:0] and data; outputs be and wdata.
  - Load inputs memFunc, addr[1:0] and read word; output extended data.
  - The misalign flag.

## Test plan
- ADDI x1,x0,5 at RESET_PC=0, zero-wait memory → rf_we pulse with waddr=1, wdata=5; pc=4; retire 5 cycles after the first accept.
- mem_req_ready low for 3 cycles in FETCH_REQ → valid and addr held constant for all 4 cycles; exactly one accept.
- SB x2 with x_data=32'h1234_56AB, addr=32'h103 → be=4'b1000, wdata=32'hABAB_ABAB, mem_req_addr=32'h100, no rf_we.
- LB with addr=32'h201, resp=32'h0000_8000 → rf_wdata=32'hFFFF_FF80. LBU at the same address → 32'h0000_0080.
- LW with addr=32'h302, or an Unsupported opcode → HALT; halted=1; no further mem_req_valid; rst_n_in low → pc=RESET_PC, halted=0.
- SEQ_PERF_CNT_EN defined, 10 ADDIs with zero-wait memory → instret_count=10, cycle_count≥50; macro undefined → both 0.

Source files
------------

// File: rtl/proc_types_pkg.sv
// Shared RV32I control types: instruction classes, ALU/branch/memory functions,
// opcode/funct3 constants and the sequencer state encoding.
package proc_types_pkg;

   typedef enum logic [3:0] {
      Unsupported,
      LUI,
      AUIPC,
      OP,
      OPIMM,
      BRANCH,
      LOAD,
      STORE,
      JAL,
      JALR,
      PMUL
   } IType;

   typedef enum logic [3:0] {
      Add, Sub, And, Or, Xor, Slt, Sltu, Sll, Srl, Sra
   } AluFunc;

   typedef enum logic [2:0] {
      Eq, Neq, Lt, Ltu, Ge, Geu
   } BrFunc;

   typedef enum logic [2:0] {
      Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb
   } MemFunc;

   typedef struct packed {
      IType        itype;
      AluFunc      alu_func;
      BrFunc       br_func;
      MemFunc      mem_func;
      logic [4:0]  dst;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [31:0] imm;
   } DecodedInst;

   typedef struct packed {
      IType        itype;
      MemFunc      mem_func;
      logic [4:0]  dst;
      logic [31:0] data;
      logic [31:0] addr;
      logic [31:0] next_pc;
   } ExecInst;

   typedef enum logic [2:0] {
      FETCH_REQ,
      FETCH_WAIT,
      DECODE,
      EXECUTE,
      MEM_REQ,
      MEM_WAIT,
      WRITEBACK,
      HALT
   } seq_state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // ADDI x0,x0,0 -- the instruction register holds a NOP out of reset.
   localparam logic [31:0] RESET_INST = 32'h0000_0013;

   function automatic logic writes_rd(input IType t);
      return (t inside {OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD, PMUL});
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment for the shared memory port: store byte
// enables and replicated data, load lane select and extension, misalign flag.
module mem_align
   import proc_types_pkg::*;
(
   input  MemFunc      mem_func_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o,
   output logic        misalign_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
      st_be_o    = 4'b0000;
      st_wdata_o = 32'h0;
      unique case (mem_func_i)
         Sb: begin
            st_be_o    = 4'b0001 << addr_lo_i;
            st_wdata_o = {4{st_data_i[7:0]}};
         end
         Sh: begin
            st_be_o    = 4'b0011 << addr_lo_i;
            st_wdata_o = {2{st_data_i[15:0]}};
         end
         Sw: begin
            st_be_o    = 4'b1111;
            st_wdata_o = st_data_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = 8'h0;
      unique case (addr_lo_i)
         2'd0: ld_byte = ld_word_i[7:0];
         2'd1: ld_byte = ld_word_i[15:8];
         2'd2: ld_byte = ld_word_i[23:16];
         2'd3: ld_byte = ld_word_i[31:24];
         default: ;
      endcase
      ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

      ld_data_o = ld_word_i;
      unique case (mem_func_i)
         Lb:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         Lbu: ld_data_o = {24'h0, ld_byte};
         Lh:  ld_data_o = {{16{ld_half[15]}}, ld_half};
         Lhu: ld_data_o = {16'h0, ld_half};
         default: ;
      endcase
   end

   always_comb begin
      misalign_o = 1'b0;
      unique case (mem_func_i)
         Lw, Sw:      misalign_o = (addr_lo_i != 2'b00);
         Lh, Lhu, Sh: misalign_o = addr_lo_i[0];
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC/IR and the single memory port.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
   import proc_types_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [31:0] inst,
   input  IType        d_itype,
   input  MemFunc      d_memfunc,
   input  logic [4:0]  d_dst,
   input  logic [31:0] x_data,
   input  logic [31:0] x_addr,
   input  logic [31:0] x_next_pc,
   output logic [31:0] pc,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        retire,
   output logic        halted,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   IType        itype_q, itype_d;
   MemFunc      memfunc_q, memfunc_d;
   logic [4:0]  dst_q, dst_d;
   logic [31:0] xdata_q, xdata_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] xnpc_q, xnpc_d;
   logic [31:0] ldata_q, ldata_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        req_we_q, req_we_d;
   logic [3:0]  req_be_q, req_be_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic        retire_q, retire_d;

   logic [1:0]  align_lo;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;
   logic        misalign;

   // Store side aligns the live execute address; load side the latched lane.
   assign align_lo = (state_q == MEM_WAIT) ? lane_q : x_addr[1:0];

   mem_align u_align (
      .mem_func_i (memfunc_q),
      .addr_lo_i  (align_lo),
      .st_data_i  (x_data),
      .st_be_o    (st_be),
      .st_wdata_o (st_wdata),
      .ld_word_i  (mem_resp_data),
      .ld_data_o  (ld_data),
      .misalign_o (misalign)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      itype_d     = itype_q;
      memfunc_d   = memfunc_q;
      dst_d       = dst_q;
      xdata_d     = xdata_q;
      lane_d      = lane_q;
      xnpc_d      = xnpc_q;
      ldata_d     = ldata_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_we_d    = req_we_q;
      req_be_d    = req_be_q;
      req_wdata_d = req_wdata_q;
      retire_d    = 1'b0;

      case (state_q)
         FETCH_REQ: begin
            // Out of reset the request register is idle; raise it once, then hold.
            if (!req_valid_q) begin
               req_valid_d = 1'b1;
               req_addr_d  = {pc_q[31:2], 2'b00};
               req_we_d    = 1'b0;
               req_be_d    = 4'b0000;
               req_wdata_d = 32'h0;
            end else if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (mem_resp_valid) begin
               inst_d  = mem_resp_data;
               state_d = DECODE;
            end
         end
         DECODE: begin
            itype_d   = d_itype;
            memfunc_d = d_memfunc;
            dst_d     = d_dst;
            state_d   = EXECUTE;
         end
         EXECUTE: begin
            xdata_d = x_data;
            lane_d  = x_addr[1:0];
            xnpc_d  = x_next_pc;
            if (itype_q == Unsupported) begin
               state_d = HALT;
            end else if (itype_q == LOAD || itype_q == STORE) begin
               if (misalign) begin
                  state_d = HALT;
               end else begin
                  req_valid_d = 1'b1;
                  req_addr_d  = {x_addr[31:2], 2'b00};
                  req_we_d    = (itype_q == STORE);
                  req_be_d    = (itype_q == STORE) ? st_be : 4'b0000;
                  req_wdata_d = (itype_q == STORE) ? st_wdata : 32'h0;
                  state_d     = MEM_REQ;
               end
            end else begin
               state_d = WRITEBACK;
            end
         end
         MEM_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               req_we_d    = 1'b0;
               req_be_d    = 4'b0000;
               req_wdata_d = 32'h0;
               state_d     = (itype_q == STORE) ? WRITEBACK : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_resp_valid) begin
               ldata_d = ld_data;
               state_d = WRITEBACK;
            end
         end
         WRITEBACK: begin
            pc_d        = xnpc_q;
            retire_d    = 1'b1;
            req_valid_d = 1'b1;
            req_addr_d  = {xnpc_q[31:2], 2'b00};
            req_we_d    = 1'b0;
            req_be_d    = 4'b0000;
            req_wdata_d = 32'h0;
            state_d     = FETCH_REQ;
         end
         HALT: ;
         default: state_d = HALT;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= FETCH_REQ;
         pc_q        <= RESET_PC;
         inst_q      <= RESET_INST;
         itype_q     <= Unsupported;
         memfunc_q   <= Lw;
         dst_q       <= 5'd0;
         xdata_q     <= 32'h0;
         lane_q      <= 2'd0;
         xnpc_q      <= 32'h0;
         ldata_q     <= 32'h0;
         req_valid_q <= 1'b0;
         req_addr_q  <= 32'h0;
         req_we_q    <= 1'b0;
         req_be_q    <= 4'b0000;
         req_wdata_q <= 32'h0;
         retire_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         itype_q     <= itype_d;
         memfunc_q   <= memfunc_d;
         dst_q       <= dst_d;
         xdata_q     <= xdata_d;
         lane_q      <= lane_d;
         xnpc_q      <= xnpc_d;
         ldata_q     <= ldata_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_be_q    <= req_be_d;
         req_wdata_q <= req_wdata_d;
         retire_q    <= retire_d;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_q;
   logic [31:0] instret_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cycle_q   <= 32'h0;
         instret_q <= 32'h0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (state_q == WRITEBACK) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`else
   assign cycle_count   = 32'h0;
   assign instret_count = 32'h0;
`endif

   assign mem_req_valid = req_valid_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_we    = req_we_q;
   assign mem_req_be    = req_be_q;
   assign mem_req_wdata = req_wdata_q;
   assign inst          = inst_q;
   assign pc            = pc_q;
   assign retire        = retire_q;
   assign halted        = (state_q == HALT);
   assign rf_we         = (state_q == WRITEBACK) && writes_rd(itype_q) && (dst_q != 5'd0);
   assign rf_waddr      = dst_q;
   assign rf_wdata      = (itype_q == LOAD) ? ldata_q : xdata_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: zero-wait/stalling memory responder,
// static decoder/executor inputs, hand-computed expectations.
module tb_cpu_sequencer;
   import proc_types_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [31:0] inst;
   IType        d_itype;
   MemFunc      d_memfunc;
   logic [4:0]  d_dst;
   logic [31:0] x_data;
   logic [31:0] x_addr;
   logic [31:0] x_next_pc;
   logic [31:0] pc;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire;
   logic        halted;
   logic [31:0] cycle_count;
   logic [31:0] instret_count;

   cpu_sequencer dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_we    (mem_req_we),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_be    (mem_req_be),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .inst          (inst),
      .d_itype       (d_itype),
      .d_memfunc     (d_memfunc),
      .d_dst         (d_dst),
      .x_data        (x_data),
      .x_addr        (x_addr),
      .x_next_pc     (x_next_pc),
      .pc            (pc),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .retire        (retire),
      .halted        (halted),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model state
   logic [31:0] inst_word = 32'h0050_0093;
   logic [31:0] load_addr = 32'hFFFF_FFFC;
   logic [31:0] load_word = 32'h0;
   int          stall_left = 0;
   int          accept_cnt = 0;
   int          store_cnt  = 0;
   int          hold_err   = 0;
   int          drop_err   = 0;
   int          req_run    = 0;
   int          last_run   = 0;
   logic [31:0] st_addr, st_wdata;
   logic [3:0]  st_be;
   logic        pend = 1'b0;
   logic [31:0] pend_data;
   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic [3:0]  prev_be;
   logic        prev_we;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
      #1;
   endtask

   // Responder: decides ready and observes requests at the falling edge,
   // answers reads on the falling edge after acceptance (one cycle later).
   initial begin
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      forever begin
         @(negedge clk_in);
         mem_resp_valid = 1'b0;
         if (!rst_n_in) begin
            pend      = 1'b0;
            prev_wait = 1'b0;
         end else begin
            if (pend) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = pend_data;
               pend           = 1'b0;
            end
            if (mem_req_valid) begin
               if (prev_wait && (mem_req_addr !== prev_addr || mem_req_we !== prev_we ||
                                 mem_req_be !== prev_be || mem_req_wdata !== prev_wdata))
                  hold_err++;
               mem_req_ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
               req_run++;
               if (mem_req_ready) begin
                  accept_cnt++;
                  last_run  = req_run;
                  req_run   = 0;
                  prev_wait = 1'b0;
                  if (mem_req_we) begin
                     store_cnt++;
                     st_addr  = mem_req_addr;
                     st_be    = mem_req_be;
                     st_wdata = mem_req_wdata;
                  end else begin
                     pend      = 1'b1;
                     pend_data = (mem_req_addr == load_addr) ? load_word : inst_word;
                  end
               end else begin
                  prev_wait  = 1'b1;
                  prev_addr  = mem_req_addr;
                  prev_we    = mem_req_we;
                  prev_be    = mem_req_be;
                  prev_wdata = mem_req_wdata;
               end
            end else begin
               if (prev_wait) drop_err++;
               prev_wait     = 1'b0;
               mem_req_ready = 1'b1;
            end
         end
      end
   end

   task automatic reset_assert();
      rst_n_in = 1'b0;
      tick();
      tick();
      accept_cnt = 0;
      store_cnt  = 0;
      req_run    = 0;
      last_run   = 0;
      stall_left = 0;
   endtask

   task automatic set_inst(input IType it, input MemFunc mf, input logic [4:0] dst,
                           input logic [31:0] xd, input logic [31:0] xa, input logic [31:0] xn);
      d_itype   = it;
      d_memfunc = mf;
      d_dst     = dst;
      x_data    = xd;
      x_addr    = xa;
      x_next_pc = xn;
   endtask

   // Waits for the first accept (cycle 0), then records the cycle of the
   // first rf_we and of retire, counted from the accept cycle.
   task automatic run_inst(output int ret_k, output int rf_k,
                           output logic [4:0] wa, output logic [31:0] wd);
      int k;
      ret_k = -1;
      rf_k  = -1;
      wa    = 5'd0;
      wd    = 32'h0;
      k     = 0;
      while (accept_cnt == 0 && k < 40) begin
         tick();
         k++;
      end
      if (accept_cnt == 0) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         for (int c = 1; c <= 20 && ret_k < 0; c++) begin
            tick();
            if (rf_we && rf_k < 0) begin
               rf_k = c;
               wa   = rf_waddr;
               wd   = rf_wdata;
            end
            if (retire) ret_k = c;
         end
         if (ret_k < 0) check("retire_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic wait_halt(input string tag);
      int k;
      k = 0;
      while (!halted && k < 40) begin
         tick();
         k++;
      end
      check(tag, {31'h0, halted}, 32'd1);
   endtask

   task automatic mem_case(input string tag, input IType it, input MemFunc mf,
                           input logic [4:0] dst, input logic [31:0] xd, input logic [31:0] xa,
                           input logic [31:0] lw, input int exp_ret, input logic [31:0] exp_wd);
      int ret_k, rf_k;
      logic [4:0]  wa;
      logic [31:0] wd;
      reset_assert();
      set_inst(it, mf, dst, xd, xa, 32'h4);
      load_addr = {xa[31:2], 2'b00};
      load_word = lw;
      rst_n_in  = 1'b1;
      run_inst(ret_k, rf_k, wa, wd);
      check({tag, "_lat"}, ret_k, exp_ret);
      if (it == LOAD && dst != 5'd0) begin
         check({tag, "_rfk"}, rf_k, exp_ret - 1);
         check({tag, "_waddr"}, {27'h0, wa}, {27'h0, dst});
         check({tag, "_wdata"}, wd, exp_wd);
      end else begin
         check({tag, "_no_rfwe"}, rf_k, -1);
      end
   endtask

   initial begin
      int ret_k, rf_k, vcnt, nret, k;
      logic [4:0]  wa;
      logic [31:0] wd;

      set_inst(OPIMM, Lw, 5'd1, 32'd5, 32'h0, 32'h4);

      // reset values
      reset_assert();
      check("rst_pc", pc, 32'h0);
      check("rst_inst", inst, 32'h0000_0013);
      check("rst_valid", {31'h0, mem_req_valid}, 32'd0);
      check("rst_we", {31'h0, mem_req_we}, 32'd0);
      check("rst_be", {28'h0, mem_req_be}, 32'd0);
      check("rst_addr", mem_req_addr, 32'h0);
      check("rst_wdata", mem_req_wdata, 32'h0);
      check("rst_rfwe", {31'h0, rf_we}, 32'd0);
      check("rst_retire", {31'h0, retire}, 32'd0);
      check("rst_halted", {31'h0, halted}, 32'd0);
      check("rst_cycles", cycle_count, 32'h0);
      check("rst_instret", instret_count, 32'h0);

      // ADDI x1,x0,5, zero-wait memory
      rst_n_in = 1'b1;
      run_inst(ret_k, rf_k, wa, wd);
      check("addi_lat", ret_k, 32'd5);
      check("addi_rfk", rf_k, 32'd4);
      check("addi_waddr", {27'h0, wa}, 32'd1);
      check("addi_wdata", wd, 32'd5);
      check("addi_pc", pc, 32'h4);
      check("addi_inst", inst, 32'h0050_0093);
      check("addi_next_addr", mem_req_addr, 32'h4);

      // fetch stalled three cycles
      reset_assert();
      stall_left = 3;
      rst_n_in   = 1'b1;
      k = 0;
      while (accept_cnt == 0 && k < 40) begin
         tick();
         k++;
      end
      check("stall_run", last_run, 32'd4);
      tick();
      tick();
      check("stall_one_accept", accept_cnt, 32'd1);

      // stores
      mem_case("sb", STORE, Sb, 5'd2, 32'h1234_56AB, 32'h103, 32'h0, 6, 32'h0);
      check("sb_cnt", store_cnt, 32'd1);
      check("sb_addr", st_addr, 32'h100);
      check("sb_be", {28'h0, st_be}, 32'h8);
      check("sb_wdata", st_wdata, 32'hABAB_ABAB);
      mem_case("sh", STORE, Sh, 5'd2, 32'h0000_BEEF, 32'h102, 32'h0, 6, 32'h0);
      check("sh_addr", st_addr, 32'h100);
      check("sh_be", {28'h0, st_be}, 32'hC);
      check("sh_wdata", st_wdata, 32'hBEEF_BEEF);
      mem_case("sw", STORE, Sw, 5'd2, 32'hDEAD_BEEF, 32'h104, 32'h0, 6, 32'h0);
      check("sw_addr", st_addr, 32'h104);
      check("sw_be", {28'h0, st_be}, 32'hF);
      check("sw_wdata", st_wdata, 32'hDEAD_BEEF);

      // loads
      mem_case("lb", LOAD, Lb, 5'd3, 32'h0, 32'h201, 32'h0000_8000, 7, 32'hFFFF_FF80);
      mem_case("lbu", LOAD, Lbu, 5'd3, 32'h0, 32'h201, 32'h0000_8000, 7, 32'h0000_0080);
      mem_case("lh", LOAD, Lh, 5'd5, 32'h0, 32'h202, 32'h8001_0000, 7, 32'hFFFF_8001);
      mem_case("lhu", LOAD, Lhu, 5'd5, 32'h0, 32'h202, 32'h8001_0000, 7, 32'h0000_8001);
      mem_case("lw", LOAD, Lw, 5'd7, 32'h0, 32'h300, 32'h1234_5678, 7, 32'h1234_5678);
      mem_case("lw_x0", LOAD, Lw, 5'd0, 32'h0, 32'h300, 32'h1234_5678, 7, 32'h0);

      // ADDI then misaligned LW -> HALT, then reset
      reset_assert();
      set_inst(OPIMM, Lw, 5'd1, 32'd5, 32'h0, 32'h4);
      rst_n_in = 1'b1;
      run_inst(ret_k, rf_k, wa, wd);
      set_inst(LOAD, Lw, 5'd4, 32'h0, 32'h302, 32'h8);
      wait_halt("lw_mis_halt");
      check("lw_mis_pc", pc, 32'h4);
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_req_valid) vcnt++;
      end
      check("halt_no_req", vcnt, 32'd0);
      check("halt_accepts", accept_cnt, 32'd2);
      rst_n_in = 1'b0;
      #1;
      check("halt_rst_pc", pc, 32'h0);
      check("halt_rst_halted", {31'h0, halted}, 32'd0);
      check("halt_rst_valid", {31'h0, mem_req_valid}, 32'd0);

      // Unsupported instruction
      reset_assert();
      set_inst(Unsupported, Lw, 5'd1, 32'h0, 32'h0, 32'h4);
      rst_n_in = 1'b1;
      wait_halt("unsup_halt");
      check("unsup_accepts", accept_cnt, 32'd1);

      // misaligned halfword store
      reset_assert();
      set_inst(STORE, Sh, 5'd0, 32'h1111, 32'h101, 32'h4);
      rst_n_in = 1'b1;
      wait_halt("sh_mis_halt");
      check("sh_mis_nostore", store_cnt, 32'd0);

      // ten ADDIs and the performance counters
      reset_assert();
      set_inst(OPIMM, Lw, 5'd1, 32'd5, 32'h0, 32'h4);
      rst_n_in = 1'b1;
      nret = 0;
      k    = 0;
      while (nret < 10 && k < 200) begin
         tick();
         k++;
         if (retire) nret++;
      end
      check("perf_retires", nret, 32'd10);
`ifdef SEQ_PERF_CNT_EN
      check("perf_instret", instret_count, 32'd10);
      check("perf_cycles_ge50", {31'h0, (cycle_count >= 32'd50)}, 32'd1);
`else
      check("perf_instret_off", instret_count, 32'd0);
      check("perf_cycles_off", cycle_count, 32'd0);
`endif

      check("hold_stable", hold_err, 32'd0);
      check("no_drop", drop_err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
